// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback-select stage.
package wb_pkg;

    localparam int unsigned WB_WIDTH   = 32;
    localparam int unsigned WB_REG_AW  = 5;
    localparam int unsigned WB_SEL_W   = 2;
    localparam int unsigned WB_NUM_SRC = 4;

    typedef logic [WB_SEL_W-1:0] wb_sel_t;

    // Writeback source indices driven by the control unit
    localparam wb_sel_t WB_SRC_ALU = 2'd0;
    localparam wb_sel_t WB_SRC_MEM = 2'd1;
    localparam wb_sel_t WB_SRC_PC4 = 2'd2;
    localparam wb_sel_t WB_SRC_LUI = 2'd3;

endpackage

// File: rtl/wb_mux_n.sv
// Combinational N-way indexed mux; out-of-range selects yield zero and flag illegal.
module wb_mux_n #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 2
) (
    input  logic [NUM_SRC*WIDTH-1:0] i_src_data,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_illegal
);

    localparam int unsigned CMP_W = SEL_W + 1;

    always_comb begin
        o_data = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A fully populated select space can never go out of range
    generate
        if (NUM_SRC < (1 << SEL_W)) begin : g_chk
            assign o_illegal = ({1'b0, i_sel} >= CMP_W'(NUM_SRC));
        end else begin : g_full
            assign o_illegal = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wb_select_stage.sv
// Writeback-source select plus MEM/WB pipeline register feeding register-file WD3/A3/WE3.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH   = WB_WIDTH,
    parameter int unsigned NUM_SRC = WB_NUM_SRC,
    parameter int unsigned SEL_W   = WB_SEL_W,
    parameter int unsigned REG_AW  = WB_REG_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [REG_AW-1:0]        rd_in,
    input  logic                     we_in,
    output logic                     wb_valid,
    output logic [WIDTH-1:0]         wd3,
    output logic [REG_AW-1:0]        a3,
    output logic                     we3,
    output logic                     sel_err,
    output logic [WIDTH-1:0]         fwd_data
);

    logic [WIDTH-1:0]  w_sel_data;
    logic              w_illegal;
    logic              w_we_qual;

    logic              r_valid;
    logic [WIDTH-1:0]  r_wd3;
    logic [REG_AW-1:0] r_a3;
    logic              r_we3;
    logic              r_sel_err;

    wb_mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .i_src_data (src_data),
        .i_sel      (src_sel),
        .o_data     (w_sel_data),
        .o_illegal  (w_illegal)
    );

    // x0 is hardwired zero, and an illegal select must never reach the register file
    assign w_we_qual = in_valid & we_in & (rd_in != '0) & ~w_illegal;

    // Priority: reset > flush > stall > load; flush leaves the data/address untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_wd3     <= '0;
            r_a3      <= '0;
            r_we3     <= 1'b0;
            r_sel_err <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_we3     <= 1'b0;
            r_sel_err <= 1'b0;
        end else if (!stall) begin
            r_valid   <= in_valid;
            r_wd3     <= w_sel_data;
            r_a3      <= rd_in;
            r_we3     <= w_we_qual;
            r_sel_err <= in_valid & w_illegal;
        end
    end

    assign wb_valid = r_valid;
    assign wd3      = r_wd3;
    assign a3       = r_a3;
    assign we3      = r_we3;
    assign sel_err  = r_sel_err;
    assign fwd_data = w_sel_data;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed plus randomized bench for wb_select_stage (4-source and 3-source instances).
module tb_wb_select_stage;
    import wb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, stall, flush, we_in;
    logic [127:0] src_data;
    logic [95:0]  src_data3;
    logic [1:0]   src_sel;
    logic [4:0]   rd_in;

    logic         v_o   [2];
    logic         we_o  [2];
    logic         err_o [2];
    logic [31:0]  wd_o  [2];
    logic [31:0]  fwd_o [2];
    logic [4:0]   a_o   [2];

    // reference model state, one entry per DUT
    logic         m_v   [2];
    logic         m_we  [2];
    logic         m_err [2];
    logic [31:0]  m_wd  [2];
    logic [4:0]   m_a   [2];
    int           nsrc  [2] = '{4, 3};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    assign src_data3 = src_data[95:0];

    wb_select_stage #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2), .REG_AW(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_data(src_data), .src_sel(src_sel), .rd_in(rd_in), .we_in(we_in),
        .wb_valid(v_o[0]), .wd3(wd_o[0]), .a3(a_o[0]), .we3(we_o[0]),
        .sel_err(err_o[0]), .fwd_data(fwd_o[0])
    );

    wb_select_stage #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .REG_AW(5)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_data(src_data3), .src_sel(src_sel), .rd_in(rd_in), .we_in(we_in),
        .wb_valid(v_o[1]), .wd3(wd_o[1]), .a3(a_o[1]), .we3(we_o[1]),
        .sel_err(err_o[1]), .fwd_data(fwd_o[1])
    );

    function automatic logic [31:0] ref_pick(input logic [127:0] d, input int sel, input int n);
        logic [127:0] sh;
        if (sel >= n) return 32'h0;
        sh = d >> (32 * sel);
        return sh[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        int sel;
        sel = int'(src_sel);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_v[i] = 0; m_we[i] = 0; m_err[i] = 0; m_wd[i] = 0; m_a[i] = 0;
            end else if (flush) begin
                m_v[i] = 0; m_we[i] = 0; m_err[i] = 0;
            end else if (!stall) begin
                m_v[i]   = in_valid;
                m_wd[i]  = ref_pick(src_data, sel, nsrc[i]);
                m_a[i]   = rd_in;
                m_err[i] = in_valid && (sel >= nsrc[i]);
                m_we[i]  = in_valid && we_in && (rd_in != 0) && (sel < nsrc[i]);
            end
        end
    endtask

    // Check forwarding before the edge, advance one edge, then check the registered outputs
    task automatic step();
        #3;
        for (int i = 0; i < 2; i++)
            check($sformatf("fwd_data[%0d]", i), fwd_o[i], ref_pick(src_data, int'(src_sel), nsrc[i]));
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wb_valid[%0d]", i), 32'(v_o[i]),   32'(m_v[i]));
            check($sformatf("wd3[%0d]", i),      wd_o[i],       m_wd[i]);
            check($sformatf("a3[%0d]", i),       32'(a_o[i]),   32'(m_a[i]));
            check($sformatf("we3[%0d]", i),      32'(we_o[i]),  32'(m_we[i]));
            check($sformatf("sel_err[%0d]", i),  32'(err_o[i]), 32'(m_err[i]));
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd, input logic we);
        in_valid = v; src_sel = sel; rd_in = rd; we_in = we;
    endtask

    initial begin
        logic [31:0] exp_wd [4];
        exp_wd = '{32'h00000011, 32'hDEADBEEF, 32'h00001004, 32'h000ABC00};
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 'x; m_we[i] = 'x; m_err[i] = 'x; m_wd[i] = 'x; m_a[i] = 'x;
        end

        // Reset held for two edges with a live write request
        rst_n = 0; stall = 0; flush = 0;
        src_data = {32'h000ABC00, 32'h00001004, 32'hDEADBEEF, 32'h00000011};
        drive(1, WB_SRC_MEM, 5'd7, 1);
        step();
        check("reset_we3", 32'(we_o[0]), 32'h0);
        check("reset_wd3", wd_o[0], 32'h0);
        step();
        rst_n = 1;

        // Source select cycling
        for (int s = 0; s < 4; s++) begin
            drive(1, 2'(s), 5'd7, 1);
            step();
            check($sformatf("sel%0d_wd3", s), wd_o[0], exp_wd[s]);
            check($sformatf("sel%0d_we3", s), 32'(we_o[0]), 32'h1);
        end

        // x0 suppression
        drive(1, WB_SRC_ALU, 5'd0, 1);
        step();
        check("x0_we3", 32'(we_o[0]), 32'h0);
        check("x0_valid", 32'(v_o[0]), 32'h1);

        // Stall holds, flush+stall kills but keeps data
        src_data[31:0] = 32'h55;
        drive(1, WB_SRC_ALU, 5'd5, 1);
        step();
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            src_data = {$urandom, $urandom, $urandom, $urandom};
            drive(1, 2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)), 1);
            step();
        end
        check("stall_wd3", wd_o[0], 32'h55);
        check("stall_a3", 32'(a_o[0]), 32'd5);
        check("stall_we3", 32'(we_o[0]), 32'h1);
        flush = 1;
        step();
        check("flush_valid", 32'(v_o[0]), 32'h0);
        check("flush_wd3", wd_o[0], 32'h55);
        stall = 0; flush = 0;

        // Illegal select on the 3-source instance
        drive(1, 2'd3, 5'd9, 1);
        step();
        check("illegal_wd3", wd_o[1], 32'h0);
        check("illegal_we3", 32'(we_o[1]), 32'h0);
        check("illegal_err", 32'(err_o[1]), 32'h1);
        drive(0, 2'd3, 5'd9, 1);
        step();
        check("illegal_bubble_err", 32'(err_o[1]), 32'h0);

        // Reset mid-stream drops the in-flight write
        drive(1, WB_SRC_PC4, 5'd12, 1);
        rst_n = 0;
        step();
        check("midrst_we3", 32'(we_o[0]), 32'h0);
        rst_n = 1;
        step();
        check("postrst_we3", 32'(we_o[0]), 32'h1);
        check("postrst_a3", 32'(a_o[0]), 32'd12);

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            rst_n    = ($urandom_range(0, 19) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            src_data = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), ($urandom_range(0, 3) != 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Writeback-source select plus MEM/WB pipeline register for the RISC-V datapath.
- Generalises the 2:1 writeback-source mux to NUM_SRC parametrised sources: ALU result, memory read data, PC+4, LUI immediate, and spares.
- Registers the selected value with the destination register address and write enable, and presents them to register-file port WD3/A3/WE3.
- Supports stall, flush, x0 write suppression and illegal-select detection.

Parameters:
- WIDTH, 32, datapath width in bits
- NUM_SRC, 4, number of writeback sources (minimum 2)
- SEL_W, 2, width of the source-select field; must satisfy 2**SEL_W >= NUM_SRC
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream (MEM stage) instruction valid
- stall  in  1  hold the WB register contents
- flush  in  1  kill the instruction entering WB
- src_data  in  NUM_SRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
- src_sel  in  SEL_W  source index from the control unit
- rd_in  in  REG_AW  destination register address
- we_in  in  1  register write request from the control unit
- wb_valid  out  1  WB stage holds a valid instruction
- wd3  out  WIDTH  registered writeback data
- a3  out  REG_AW  registered destination address
- we3  out  1  registered, qualified register-file write enable
- sel_err  out  1  registered flag: the instruction now in WB had an illegal select
- fwd_data  out  WIDTH  combinational selected value (pre-register), for forwarding

Behaviour:
- Clocking and reset: one clock domain, all state updated on the rising edge of clk. Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge): wb_valid=0, wd3=0, a3=0, we3=0, sel_err=0. Reset overrides flush and stall. Asserting reset mid-stream drops the in-flight instruction with no write.
- Update priority at each edge: reset > flush > stall > load.
- Flush: wb_valid=0, we3=0, sel_err=0. wd3 and a3 hold their previous values.
- Stall (flush=0): every output register holds its value, including we3. The register file may rewrite the same value, which is harmless.
- Load (flush=0, stall=0):
  - wb_valid <= in_valid
  - wd3 <= selected data
  - a3 <= rd_in
  - sel_err <= in_valid & illegal
  - we3 <= in_valid & we_in & (rd_in != 0) & ~illegal
- Select rule: illegal = (src_sel >= NUM_SRC). If illegal, the selected data is 0; otherwise it is src_data slice src_sel.
- fwd_data: always equals the selected data for the current inputs, zero-latency, unaffected by stall or flush.
- Latency: exactly 1 cycle from inputs to wd3/a3/we3.
- x0 rule: rd_in==0 never produces we3=1, regardless of we_in.
- in_valid=0 loads a bubble. wd3 and a3 still load, so they are don't-care with we3=0.
- Simultaneous flush and stall: flush wins.
- NUM_SRC = 2**SEL_W: illegal is constant 0; logic must synthesise without warnings.

Decomposition:
- Package wb_pkg:
  - WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_PC4=2, WB_SRC_LUI=3
  - default WIDTH and REG_AW constants
  - typedef for the sel field
- Sub-module wb_mux_n (parameters WIDTH, NUM_SRC, SEL_W): purely combinational indexed mux with a zero default; outputs data and illegal. wb_select_stage instantiates it once and adds the register and qualification logic.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with we_in=1, in_valid=1 -> wb_valid=0, we3=0, wd3=0, a3=0, sel_err=0 after the first edge.
- Source select: src_data={0x000ABC00, 0x00001004, 0xDEADBEEF, 0x00000011}, rd_in=7, we_in=1, in_valid=1, sel cycling 0..3 -> one cycle later wd3 = 0x11, 0xDEADBEEF, 0x1004, 0xABC00 in turn. a3=7, we3=1. fwd_data matches in the same cycle.
- x0 suppression: sel=WB_SRC_ALU, rd_in=0, we_in=1 -> wd3 loads, we3=0, wb_valid=1.
- Stall and flush: load rd=5, data=0x55; assert stall 3 cycles with new inputs -> outputs hold 0x55/5/we3=1. Assert flush+stall together -> wb_valid=0, we3=0, wd3 stays 0x55.
- Illegal select: instantiate NUM_SRC=3, SEL_W=2; sel=3, in_valid=1, we_in=1, rd=9 -> wd3=0, we3=0, sel_err=1. The same stimulus with in_valid=0 gives sel_err=0.
- Reset mid-stream: rst_n=0 at the same edge as a load with we_in=1, rd=12 -> we3=0. After release, the next load writes normally.
